// File: rtl/alu_pkg.sv
// Shared ALUOp/funct codes, internal op and FSM enums, and the ALUOp/funct decoder.
// ALU_DIV_EN enables DIV/DIVU decode; without it they decode as illegal.
package alu_pkg;

  localparam logic [3:0] AOP_ADD   = 4'b0000;
  localparam logic [3:0] AOP_SUB   = 4'b0001;
  localparam logic [3:0] AOP_RTYPE = 4'b0010;
  localparam logic [3:0] AOP_LUI   = 4'b0011;
  localparam logic [3:0] AOP_OR    = 4'b0100;
  localparam logic [3:0] AOP_AND   = 4'b0101;
  localparam logic [3:0] AOP_XOR   = 4'b0110;
  localparam logic [3:0] AOP_SLT   = 4'b1000;
  localparam logic [3:0] AOP_SLTU  = 4'b1001;
  localparam logic [3:0] AOP_NOR   = 4'b1010;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
  } op_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  typedef struct packed {
    op_t  op;
    logic ovf_chk;  // signed overflow reported (ADD/SUB flavours only)
    logic var_sh;   // shift amount taken from src_a instead of shamt
  } dec_t;

  function automatic dec_t decode(input logic [3:0] alu_op, input logic [5:0] funct);
    dec_t d;
    d.op      = OP_ILL;
    d.ovf_chk = 1'b0;
    d.var_sh  = 1'b0;
    case (alu_op)
      AOP_ADD:  begin d.op = OP_ADD; d.ovf_chk = 1'b1; end
      AOP_SUB:  begin d.op = OP_SUB; d.ovf_chk = 1'b1; end
      AOP_LUI:  d.op = OP_LUI;
      AOP_AND:  d.op = OP_AND;
      AOP_OR:   d.op = OP_OR;
      AOP_XOR:  d.op = OP_XOR;
      AOP_NOR:  d.op = OP_NOR;
      AOP_SLT:  d.op = OP_SLT;
      AOP_SLTU: d.op = OP_SLTU;
      AOP_RTYPE: begin
        case (funct)
          FN_ADD:   begin d.op = OP_ADD; d.ovf_chk = 1'b1; end
          FN_ADDU:  d.op = OP_ADD;
          FN_SUB:   begin d.op = OP_SUB; d.ovf_chk = 1'b1; end
          FN_SUBU:  d.op = OP_SUB;
          FN_AND:   d.op = OP_AND;
          FN_OR:    d.op = OP_OR;
          FN_XOR:   d.op = OP_XOR;
          FN_NOR:   d.op = OP_NOR;
          FN_SLT:   d.op = OP_SLT;
          FN_SLTU:  d.op = OP_SLTU;
          FN_SLL:   d.op = OP_SLL;
          FN_SRL:   d.op = OP_SRL;
          FN_SRA:   d.op = OP_SRA;
          FN_SLLV:  begin d.op = OP_SLL; d.var_sh = 1'b1; end
          FN_SRLV:  begin d.op = OP_SRL; d.var_sh = 1'b1; end
          FN_SRAV:  begin d.op = OP_SRA; d.var_sh = 1'b1; end
          FN_MFHI:  d.op = OP_MFHI;
          FN_MFLO:  d.op = OP_MFLO;
          FN_MTHI:  d.op = OP_MTHI;
          FN_MTLO:  d.op = OP_MTLO;
          FN_MULT:  d.op = OP_MULT;
          FN_MULTU: d.op = OP_MULTU;
`ifdef ALU_DIV_EN
          FN_DIV:   d.op = OP_DIV;
          FN_DIVU:  d.op = OP_DIVU;
`else
          FN_DIV, FN_DIVU: d.op = OP_ILL;
`endif
          default:  d.op = OP_ILL;
        endcase
      end
      default: d.op = OP_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_md_seq.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes, signs fixed on output.
// The divider datapath exists only when ALU_DIV_EN is defined.
module alu_md_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = SHAMT_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, dvsr;
  logic               neg_q;
  logic [WIDTH-1:0]   nxt_hi, nxt_lo;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  // acc_lo starts as the multiplier and is shifted out as product bits shift in
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvsr} : '0);
  assign prod    = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign done    = (cnt == CNT_W'(1));

`ifdef ALU_DIV_EN
  logic           div_mode, neg_r, b_zero, ge;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH-1:0] rem_sub;

  assign rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign ge      = (rem_sh >= {1'b0, dvsr});
  assign rem_sub = rem_sh[WIDTH-1:0] - dvsr;
  assign nxt_hi  = div_mode ? (ge ? rem_sub : rem_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
  assign nxt_lo  = div_mode ? {acc_lo[WIDTH-2:0], ge} : {mul_sum[0], acc_lo[WIDTH-1:1]};
  // Divide by zero leaves the dividend magnitude in acc_hi, so re-signing it restores the dividend
  assign hi_res  = div_mode ? (neg_r ? -acc_hi : acc_hi) : prod[2*WIDTH-1:WIDTH];
  assign lo_res  = div_mode ? (b_zero ? '1 : (neg_q ? -acc_lo : acc_lo)) : prod[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_mode <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
    end else if (start && !abort) begin
      div_mode <= is_div;
      neg_r    <= is_signed & a[WIDTH-1];
      b_zero   <= (b == '0);
    end
  end
`else
  logic unused_div;
  assign unused_div = is_div;
  assign nxt_hi = mul_sum[WIDTH:1];
  assign nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
  assign hi_res = prod[2*WIDTH-1:WIDTH];
  assign lo_res = prod[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      dvsr   <= '0;
      neg_q  <= 1'b0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      cnt    <= CNT_W'(WIDTH);
      acc_hi <= '0;
      acc_lo <= mag(a, is_signed);
      dvsr   <= mag(b, is_signed);
      neg_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (cnt != '0) begin
      cnt    <= cnt - CNT_W'(1);
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
    end
  end

endmodule

// File: rtl/alu_md_unit.sv
// Execute-stage ALU: decode, single-cycle ALU, HI/LO and the mul/div sequencing FSM.
// ALU_DIV_EN enables DIV/DIVU; otherwise they complete as illegal in one cycle.
module alu_md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = SHAMT_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               illegal,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  state_t             state;
  dec_t               dec;
  logic [SHAMT_W-1:0] sh;
  logic [WIDTH-1:0]   sum, diff, alu_res, seq_hi, seq_lo;
  logic               alu_ovf, is_md, is_div, md_start, seq_done;

  assign dec      = decode(alu_op, funct);
  assign sh       = dec.var_sh ? src_a[SHAMT_W-1:0] : shamt;
  assign sum      = src_a + src_b;
  assign diff     = src_a - src_b;
  assign is_div   = (dec.op == OP_DIV) || (dec.op == OP_DIVU);
  assign is_md    = is_div || (dec.op == OP_MULT) || (dec.op == OP_MULTU);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign md_start = in_ready && in_valid && !flush && is_md;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (dec.op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = dec.ovf_chk && (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = dec.ovf_chk && (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_NOR:  alu_res = ~(src_a | src_b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
      OP_SLL:  alu_res = src_b << sh;
      OP_SRL:  alu_res = src_b >> sh;
      OP_SRA:  alu_res = $unsigned($signed(src_b) >>> sh);
      OP_LUI:  alu_res = {src_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  alu_md_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .CNT_W(CNT_W)) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (md_start),
    .abort     (flush),
    .is_div    (is_div),
    .is_signed ((dec.op == OP_MULT) || (dec.op == OP_DIV)),
    .a         (src_a),
    .b         (src_b),
    .done      (seq_done),
    .hi_res    (seq_hi),
    .lo_res    (seq_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            if (is_md) begin
              state <= is_div ? DIV : MUL;
            end else begin
              out_valid <= 1'b1;
              result    <= alu_res;
              zero      <= (alu_res == '0);
              overflow  <= alu_ovf;
              illegal   <= (dec.op == OP_ILL);
              if (dec.op == OP_MTHI) hi <= src_a;
              if (dec.op == OP_MTLO) lo <= src_a;
            end
          end
        end
        MUL, DIV: begin
          if (flush)         state <= IDLE;
          else if (seq_done) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          if (!flush) begin
            hi        <= seq_hi;
            lo        <= seq_lo;
            out_valid <= 1'b1;
            result    <= '0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_unit.sv
// Self-checking bench for alu_md_unit: transaction-level reference model plus per-cycle compare.
// Honours ALU_DIV_EN in the model the same way the build does.
module tb_alu_md_unit;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [3:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] src_a, src_b, result, hi, lo;
  logic        out_valid, zero, overflow, illegal, busy;

  alu_md_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .shamt(shamt), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .result(result), .zero(zero), .overflow(overflow),
    .illegal(illegal), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  logic chk_en = 1'b0;

  // Model state: architectural HI/LO plus the one pending transaction
  logic [31:0] m_hi = '0, m_lo = '0;
  int          pend_due = -1, busy_from = -1, busy_to = -2;
  logic [31:0] pend_res, pend_hi, pend_lo;
  logic        pend_ovf, pend_ill, pend_whi, pend_wlo;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic void model(input logic [3:0] aop, input logic [5:0] fn, input logic [4:0] sh,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic ovf, output logic ill,
                                output logic md, output logic whi, output logic wlo,
                                output logic [31:0] nhi, output logic [31:0] nlo);
    int sa, sb;
    longint s;
    logic [63:0] p;
    sa = a; sb = b;
    res = '0; ovf = 1'b0; ill = 1'b0; md = 1'b0; whi = 1'b0; wlo = 1'b0;
    nhi = m_hi; nlo = m_lo;
    case (aop)
      4'h0: begin res = a + b; s = longint'(sa) + longint'(sb); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'h1: begin res = a - b; s = longint'(sa) - longint'(sb); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'h3: res = {b[15:0], 16'h0000};
      4'h4: res = a | b;
      4'h5: res = a & b;
      4'h6: res = a ^ b;
      4'hA: res = ~(a | b);
      4'h8: res = (sa < sb) ? 32'd1 : 32'd0;
      4'h9: res = (a < b) ? 32'd1 : 32'd0;
      4'h2: begin
        case (fn)
          6'h20: begin res = a + b; s = longint'(sa) + longint'(sb); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
          6'h21: res = a + b;
          6'h22: begin res = a - b; s = longint'(sa) - longint'(sb); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
          6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
          6'h2B: res = (a < b) ? 32'd1 : 32'd0;
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          6'h03: res = sb >>> sh;
          6'h04: res = b << a[4:0];
          6'h06: res = b >> a[4:0];
          6'h07: res = sb >>> a[4:0];
          6'h10: res = m_hi;
          6'h12: res = m_lo;
          6'h11: begin whi = 1'b1; nhi = a; end
          6'h13: begin wlo = 1'b1; nlo = a; end
          6'h18: begin md = 1'b1; whi = 1'b1; wlo = 1'b1; p = longint'(sa) * longint'(sb); {nhi, nlo} = p; end
          6'h19: begin md = 1'b1; whi = 1'b1; wlo = 1'b1; p = {32'h0, a} * {32'h0, b}; {nhi, nlo} = p; end
`ifdef ALU_DIV_EN
          6'h1A: begin
            md = 1'b1; whi = 1'b1; wlo = 1'b1;
            if (b == 0)                              begin nlo = '1; nhi = a; end
            else if (a == 32'h80000000 && sb == -1)  begin nlo = 32'h80000000; nhi = 0; end
            else                                     begin nlo = sa / sb; nhi = sa % sb; end
          end
          6'h1B: begin
            md = 1'b1; whi = 1'b1; wlo = 1'b1;
            if (b == 0) begin nlo = '1; nhi = a; end
            else        begin nlo = a / b; nhi = a % b; end
          end
`endif
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin : cmp
    logic ev, rdy;
    if (chk_en) begin
      ev = (cyc == pend_due);
      if (ev) begin
        if (pend_whi) m_hi = pend_hi;
        if (pend_wlo) m_lo = pend_lo;
      end
      rdy = !(cyc >= busy_from && cyc <= busy_to);
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("busy", 64'(busy), 64'(!rdy));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      if (ev) begin
        chk("result", 64'(result), 64'(pend_res));
        chk("zero", 64'(zero), 64'(pend_res == 0));
        chk("overflow", 64'(overflow), 64'(pend_ovf));
        chk("illegal", 64'(illegal), 64'(pend_ill));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_flags"}, 64'({zero, overflow, illegal}), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'd0);
    chk({tag, "_lo"}, 64'(lo), 64'd0);
  endtask

  // flush_after: -1 none, 0 flush with the request, k>0 flush k cycles into a mul/div.
  // rst_after: -1 none, k>0 async reset k cycles after accept.
  task automatic issue(input logic [3:0] aop, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b,
                       input int flush_after, input int rst_after);
    logic [31:0] res, nhi, nlo;
    logic ovf, ill, md, whi, wlo, fl;
    int n;
    @(negedge clk);
    model(aop, fn, sh, a, b, res, ovf, ill, md, whi, wlo, nhi, nlo);
    n  = cyc + 1;
    fl = md && (flush_after > 0);
    alu_op = aop; funct = fn; shamt = sh; src_a = a; src_b = b;
    in_valid = 1'b1;
    flush = (flush_after == 0);
    if (flush_after == 0) begin
      pend_due = -1;
    end else begin
      pend_due = fl ? -1 : n + (md ? W + 1 : 0);
      pend_res = res; pend_ovf = ovf; pend_ill = ill;
      pend_whi = whi; pend_wlo = wlo; pend_hi = nhi; pend_lo = nlo;
      if (md) begin
        busy_from = n;
        busy_to   = fl ? n + flush_after - 1 : n + W;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    src_a = $urandom(); src_b = $urandom(); funct = 6'($urandom()); alu_op = 4'($urandom());
    if (fl) begin
      while (cyc < n + flush_after - 1) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end else if (rst_after > 0) begin
      while (cyc < n + rst_after) @(negedge clk);
      chk_en = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("async_rst");
      m_hi = '0; m_lo = '0; pend_due = -1; busy_from = -1; busy_to = -2;
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;
    end else begin
      while (cyc < pend_due) @(negedge clk);
    end
    $display("txn aop=%h fn=%h sh=%0d a=%h b=%h fl=%0d rst=%0d -> res=%h hi=%h lo=%h",
             aop, fn, sh, a, b, flush_after, rst_after, result, hi, lo);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h7FFFFFFF;
      4: return 32'h80000000;
      default: return $urandom();
    endcase
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] aops [10];
    logic [5:0] fns [22];
    logic [3:0] aop;
    logic [5:0] fn;
    int r, fa;
    aops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA};
    fns  = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11, 6'h12, 6'h13, 6'h20,
             6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h10, 6'h12};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    alu_op = '0; funct = '0; shamt = '0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Directed cases with hand-computed expectations
    issue(4'h2, 6'h20, 5'd0, 32'h7FFFFFFF, 32'h1, -1, -1);
    chk("add_ovf_result", 64'(result), 64'h80000000);
    chk("add_ovf_flag", 64'(overflow), 64'd1);
    issue(4'h3, 6'h00, 5'd0, 32'h0, 32'h00001234, -1, -1);
    chk("lui_result", 64'(result), 64'h12340000);
    issue(4'h2, 6'h03, 5'd4, 32'h0, 32'h80000000, -1, -1);
    chk("sra_result", 64'(result), 64'hF8000000);
    issue(4'h2, 6'h18, 5'd0, 32'hFFFFFFFD, 32'd7, -1, -1);
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFEB);
    chk("mult_zero", 64'(zero), 64'd1);
`ifdef ALU_DIV_EN
    issue(4'h2, 6'h1A, 5'd0, 32'hFFFFFFF9, 32'd2, -1, -1);
    chk("div_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_hi", 64'(hi), 64'hFFFFFFFF);
    issue(4'h2, 6'h1B, 5'd0, 32'd5, 32'd0, -1, -1);
    chk("divu0_lo", 64'(lo), 64'hFFFFFFFF);
    chk("divu0_hi", 64'(hi), 64'd5);
    issue(4'h2, 6'h1A, 5'd0, 32'h80000000, 32'hFFFFFFFF, -1, -1);
    chk("divmin_lo", 64'(lo), 64'h80000000);
    chk("divmin_hi", 64'(hi), 64'd0);
`else
    issue(4'h2, 6'h1A, 5'd0, 32'hFFFFFFF9, 32'd2, -1, -1);
    chk("div_illegal", 64'(illegal), 64'd1);
    chk("div_illegal_hi", 64'(hi), 64'hFFFFFFFF);
`endif
    issue(4'h2, 6'h19, 5'd0, 32'h12345678, 32'h9ABCDEF0, 10, -1);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
`ifdef ALU_DIV_EN
    chk("flush_hi_kept", 64'(hi), 64'd0);
    chk("flush_lo_kept", 64'(lo), 64'h80000000);
`else
    chk("flush_hi_kept", 64'(hi), 64'hFFFFFFFF);
    chk("flush_lo_kept", 64'(lo), 64'hFFFFFFEB);
`endif
    issue(4'h2, 6'h11, 5'd0, 32'hDEADBEEF, 32'h0, 0, -1);
    issue(4'h2, 6'h10, 5'd0, 32'h0, 32'h0, -1, -1);
`ifdef ALU_DIV_EN
    issue(4'h2, 6'h1A, 5'd0, 32'd100, 32'd7, -1, 12);
`else
    issue(4'h2, 6'h18, 5'd0, 32'd100, 32'd7, -1, 12);
`endif
    issue(4'h2, 6'h11, 5'd0, 32'hCAFEF00D, 32'h0, -1, -1);
    issue(4'h2, 6'h10, 5'd0, 32'h0, 32'h0, -1, -1);
    chk("mthi_mfhi", 64'(result), 64'hCAFEF00D);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      r  = $urandom_range(0, 99);
      fa = -1;
      if (r < 12) begin
        aop = 4'h2;
        fn  = 6'h18 + 6'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) fa = $urandom_range(1, W + 1);
      end else if (r < 20) begin
        aop = 4'($urandom());
        fn  = 6'($urandom());
      end else begin
        aop = aops[$urandom_range(0, 9)];
        fn  = fns[$urandom_range(0, 21)];
        if ($urandom_range(0, 19) == 0) fa = 0;
      end
      issue(aop, fn, 5'($urandom()), rnd_opnd(), rnd_opnd(), fa, -1);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
